// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared constants for the HD44780-style LCD responder: instruction opcode
// masks, DDRAM geometry, the blank character and the default busy counts.
// Also holds the state type for the DDRAM clear-fill sequencer.
// ---------------------------------------------------------------------------
package lcd_pkg;

    // Instruction opcodes. Each is the highest set bit of its instruction
    // group, so the decoder can classify a byte by its leading one.
    localparam logic [7:0] CLR   = 8'h01;
    localparam logic [7:0] HOME  = 8'h02;
    localparam logic [7:0] ENTRY = 8'h04;
    localparam logic [7:0] DISP  = 8'h08;
    localparam logic [7:0] DDRAM = 8'h80;

    // Two lines of 16 characters, flattened into one 32-entry buffer.
    localparam int         DDRAM_DEPTH = 32;
    localparam int         ADDR_W      = 5;
    localparam logic [7:0] SPACE       = 8'h20;

    // 40 us and 1.64 ms at 50 MHz.
    localparam int DEF_BUSY_CYCLES  = 2000;
    localparam int DEF_CLEAR_CYCLES = 82000;

    typedef enum logic [0:0] {
        FILL_IDLE = 1'b0,
        FILL_RUN  = 1'b1
    } fill_state_e;

endpackage

// File: rtl/lcd_strobe_capture.sv
// ---------------------------------------------------------------------------
// lcd_strobe_capture
// Detects the falling edge of the LCD enable strobe and holds the bus fields
// (RS, RW, data) as they were on the last cycle enable was high.
//
// Ports:
//   clk_i, reset_i  : clock, synchronous active-high reset
//   en_i            : LCD enable from the controller
//   rs_i, rw_i      : register select, read/write
//   data_i [7:0]    : LCD data bus
//   strobe_o        : high in the cycle where en was 1 last cycle and is 0 now
//   rs_o, rw_o      : captured RS / RW
//   data_o [7:0]    : captured data byte
//
// Strobe semantics: strobe_o is a single-cycle, combinational indication with
// no back-pressure; the consumer must act on it in that same cycle (its
// registered effects appear the cycle after). rs_o/rw_o/data_o are stable
// while strobe_o is high.
// ---------------------------------------------------------------------------
module lcd_strobe_capture (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       en_i,
    input  logic       rs_i,
    input  logic       rw_i,
    input  logic [7:0] data_i,
    output logic       strobe_o,
    output logic       rs_o,
    output logic       rw_o,
    output logic [7:0] data_o
);

    logic       en_q,   en_d;
    logic       rs_q,   rs_d;
    logic       rw_q,   rw_d;
    logic [7:0] data_q, data_d;

    always_comb begin
        en_d   = en_i;
        rs_d   = rs_q;
        rw_d   = rw_q;
        data_d = data_q;
        // Track the bus only while enable is high, so the values seen at the
        // falling edge are those from the final high cycle.
        if (en_i) begin
            rs_d   = rs_i;
            rw_d   = rw_i;
            data_d = data_i;
        end
    end

    // en_q clears in reset, so an enable that falls right after reset
    // release has no "previous high" and is not taken as a strobe.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            en_q   <= 1'b0;
            rs_q   <= 1'b0;
            rw_q   <= 1'b0;
            data_q <= 8'h00;
        end else begin
            en_q   <= en_d;
            rs_q   <= rs_d;
            rw_q   <= rw_d;
            data_q <= data_d;
        end
    end

    assign strobe_o = en_q & ~en_i;
    assign rs_o     = rs_q;
    assign rw_o     = rw_q;
    assign data_o   = data_q;

endmodule

// File: rtl/lcd_responder.sv
// ---------------------------------------------------------------------------
// lcd_responder
// Behavioural model of a 2x16 character LCD as seen from its parallel bus.
// Decodes instructions and data writes, emulates the busy time, keeps a
// 32-byte DDRAM with a cursor, and offers a registered readback port.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   lcd_data [7:0]        : bus data
//   lcd_en, lcd_rs, lcd_rw: bus strobe, register select, read/write
//   rd_addr [4:0]         : DDRAM readback index (0-15 line 1, 16-31 line 2)
//   rd_char [7:0]         : DDRAM[rd_addr], one cycle later
//   cursor [4:0]          : current DDRAM index
//   busy                  : high while the emulated busy time runs
//   display_on            : display-on bit of display control
//   cmd_valid, cmd_code   : one-cycle pulse + last accepted instruction byte
//   err_overrun           : sticky, strobe arrived while busy
//   err_rw                : sticky, read strobe seen (reads unsupported)
//   err_addr              : sticky, set-DDRAM-address with bits [5:4] set
// ---------------------------------------------------------------------------
module lcd_responder
    import lcd_pkg::*;
#(
    parameter int BUSY_CYCLES  = DEF_BUSY_CYCLES,
    parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        lcd_data,
    input  logic              lcd_en,
    input  logic              lcd_rs,
    input  logic              lcd_rw,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_char,
    output logic [ADDR_W-1:0] cursor,
    output logic              busy,
    output logic              display_on,
    output logic              cmd_valid,
    output logic [7:0]        cmd_code,
    output logic              err_overrun,
    output logic              err_rw,
    output logic              err_addr
);

    localparam int MAX_CYCLES = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic       stb;
    logic       stb_rs;
    logic       stb_rw;
    logic [7:0] stb_data;

    lcd_strobe_capture u_capture (
        .clk_i    (clk),
        .reset_i  (reset),
        .en_i     (lcd_en),
        .rs_i     (lcd_rs),
        .rw_i     (lcd_rw),
        .data_i   (lcd_data),
        .strobe_o (stb),
        .rs_o     (stb_rs),
        .rw_o     (stb_rw),
        .data_o   (stb_data)
    );

    logic [CNT_W-1:0]  busy_cnt_q,   busy_cnt_d;
    logic [ADDR_W-1:0] cursor_q,     cursor_d;
    logic              id_q,         id_d;
    logic              disp_q,       disp_d;
    logic              cmd_valid_q,  cmd_valid_d;
    logic [7:0]        cmd_code_q,   cmd_code_d;
    logic              err_ovr_q,    err_ovr_d;
    logic              err_rw_q,     err_rw_d;
    logic              err_addr_q,   err_addr_d;
    logic [7:0]        rd_char_q,    rd_char_d;
    fill_state_e       fill_state_q, fill_state_d;
    logic [ADDR_W-1:0] fill_idx_q,   fill_idx_d;
    logic [7:0]        mem_q [DDRAM_DEPTH];
    logic [7:0]        mem_d [DDRAM_DEPTH];

    logic busy_now;
    assign busy_now = (busy_cnt_q != '0);

    always_comb begin
        busy_cnt_d   = busy_now ? (busy_cnt_q - CNT_W'(1)) : busy_cnt_q;
        cursor_d     = cursor_q;
        id_d         = id_q;
        disp_d       = disp_q;
        cmd_valid_d  = 1'b0;
        cmd_code_d   = cmd_code_q;
        err_ovr_d    = err_ovr_q;
        err_rw_d     = err_rw_q;
        err_addr_d   = err_addr_q;
        fill_state_d = fill_state_q;
        fill_idx_d   = fill_idx_q;
        mem_d        = mem_q;
        // Read uses the pre-write array, so a same-cycle write to the same
        // index shows the old byte here.
        rd_char_d    = mem_q[rd_addr];

        // Clear fill: one byte per cycle from index 0 up to 31. The clear
        // busy time is at least 32 cycles, so no data write can interleave.
        case (fill_state_q)
            FILL_RUN: begin
                mem_d[fill_idx_q] = SPACE;
                fill_idx_d        = fill_idx_q + ADDR_W'(1);
                if (fill_idx_q == ADDR_W'(DDRAM_DEPTH - 1)) begin
                    fill_state_d = FILL_IDLE;
                end
            end
            default: ;
        endcase

        if (stb) begin
            if (stb_rw) begin
                err_rw_d = 1'b1;
            end else if (busy_now) begin
                // Dropped: busy count keeps running down untouched.
                err_ovr_d = 1'b1;
            end else begin
                busy_cnt_d = CNT_W'(BUSY_CYCLES);
                if (!stb_rs) begin
                    cmd_valid_d = 1'b1;
                    cmd_code_d  = stb_data;
                    // Classify by the leading one of the instruction byte.
                    if ((stb_data & DDRAM) != 8'h00) begin
                        cursor_d = {stb_data[6], stb_data[3:0]};
                        if (stb_data[5:4] != 2'b00) begin
                            err_addr_d = 1'b1;
                        end
                    end else if (stb_data[6:4] != 3'b000) begin
                        // Shift, function set, CGRAM address: acknowledge only.
                    end else if ((stb_data & DISP) != 8'h00) begin
                        disp_d = stb_data[2];
                    end else if ((stb_data & ENTRY) != 8'h00) begin
                        id_d = stb_data[1];
                    end else if ((stb_data & HOME) != 8'h00) begin
                        cursor_d   = '0;
                        busy_cnt_d = CNT_W'(CLEAR_CYCLES);
                    end else if ((stb_data & CLR) != 8'h00) begin
                        cursor_d     = '0;
                        id_d         = 1'b1;
                        busy_cnt_d   = CNT_W'(CLEAR_CYCLES);
                        fill_state_d = FILL_RUN;
                        fill_idx_d   = '0;
                    end
                end else begin
                    mem_d[cursor_q] = stb_data;
                    // 5-bit arithmetic gives the 31<->0 wrap for free.
                    cursor_d = id_q ? (cursor_q + ADDR_W'(1)) : (cursor_q - ADDR_W'(1));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_cnt_q   <= '0;
            cursor_q     <= '0;
            id_q         <= 1'b1;
            disp_q       <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_code_q   <= 8'h00;
            err_ovr_q    <= 1'b0;
            err_rw_q     <= 1'b0;
            err_addr_q   <= 1'b0;
            rd_char_q    <= 8'h00;
            fill_state_q <= FILL_IDLE;
            fill_idx_q   <= '0;
            for (int i = 0; i < DDRAM_DEPTH; i++) begin
                mem_q[i] <= SPACE;
            end
        end else begin
            busy_cnt_q   <= busy_cnt_d;
            cursor_q     <= cursor_d;
            id_q         <= id_d;
            disp_q       <= disp_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_code_q   <= cmd_code_d;
            err_ovr_q    <= err_ovr_d;
            err_rw_q     <= err_rw_d;
            err_addr_q   <= err_addr_d;
            rd_char_q    <= rd_char_d;
            fill_state_q <= fill_state_d;
            fill_idx_q   <= fill_idx_d;
            for (int i = 0; i < DDRAM_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rd_char     = rd_char_q;
    assign cursor      = cursor_q;
    assign busy        = busy_now;
    assign display_on  = disp_q;
    assign cmd_valid   = cmd_valid_q;
    assign cmd_code    = cmd_code_q;
    assign err_overrun = err_ovr_q;
    assign err_rw      = err_rw_q;
    assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_lcd_responder.sv
// ---------------------------------------------------------------------------
// tb_lcd_responder
// Directed bench for lcd_responder: bus strobes driven by tasks, outputs
// sampled 1 ns after the rising edge, expected values written by hand.
// ---------------------------------------------------------------------------
module tb_lcd_responder;

    localparam int BUSY_N  = 200;
    localparam int CLEAR_N = 82000;
    localparam int LIMIT   = 100000;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] lcd_data;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;
    logic [4:0] cursor;
    logic       busy;
    logic       display_on;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic       err_overrun;
    logic       err_rw;
    logic       err_addr;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    lcd_responder #(
        .BUSY_CYCLES  (BUSY_N),
        .CLEAR_CYCLES (CLEAR_N)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .lcd_data    (lcd_data),
        .lcd_en      (lcd_en),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .rd_addr     (rd_addr),
        .rd_char     (rd_char),
        .cursor      (cursor),
        .busy        (busy),
        .display_on  (display_on),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .err_overrun (err_overrun),
        .err_rw      (err_rw),
        .err_addr    (err_addr)
    );

    // Clock
    always #5 clk = ~clk;

    // Counts cmd_valid pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (cmd_valid === 1'b1) pulses++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus transaction; returns 1 ns after the edge on which the DUT acts.
    task automatic do_strobe(input logic rs, input logic rw, input logic [7:0] d);
        @(posedge clk);
        #1;
        lcd_rs   = rs;
        lcd_rw   = rw;
        lcd_data = d;
        lcd_en   = 1'b1;
        @(posedge clk);
        #1;
        lcd_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < LIMIT) begin
            n++;
            tick();
        end
    endtask

    task automatic read_ddr(input int a, output logic [7:0] v);
        rd_addr = a[4:0];
        tick();
        v = rd_char;
    endtask

    task automatic check_all_space(input string tag, input int skip, input logic [7:0] skip_val);
        logic [7:0] v;
        for (int i = 0; i < 32; i++) begin
            read_ddr(i, v);
            check_val($sformatf("%s[%0d]", tag, i), {24'h0, v}, (i == skip) ? {24'h0, skip_val} : 32'h20);
        end
    endtask

    initial begin
        int         n;
        int         p0;
        logic [7:0] v;

        reset    = 1'b1;
        lcd_en   = 1'b0;
        lcd_rs   = 1'b0;
        lcd_rw   = 1'b0;
        lcd_data = 8'h00;
        rd_addr  = 5'd0;

        // Reset state
        repeat (3) tick();
        check_val("rst_busy",   {31'h0, busy}, 32'h0);
        check_val("rst_cmdv",   {31'h0, cmd_valid}, 32'h0);
        check_val("rst_code",   {24'h0, cmd_code}, 32'h0);
        check_val("rst_cursor", {27'h0, cursor}, 32'h0);
        check_val("rst_disp",   {31'h0, display_on}, 32'h0);
        check_val("rst_rdchar", {24'h0, rd_char}, 32'h0);
        check_val("rst_errs",   {29'h0, err_overrun, err_rw, err_addr}, 32'h0);
        reset = 1'b0;
        tick();
        read_ddr(31, v);
        check_val("rst_ddr31", {24'h0, v}, 32'h20);

        // Data write, then clear, then 'A'
        do_strobe(1'b1, 1'b0, 8'h5A);
        check_val("w5a_cmdv",   {31'h0, cmd_valid}, 32'h0);
        check_val("w5a_cursor", {27'h0, cursor}, 32'h1);
        count_busy(n);
        check_val("w5a_busyn", n, BUSY_N);
        do_strobe(1'b0, 1'b0, 8'h01);
        check_val("clr_cmdv",   {31'h0, cmd_valid}, 32'h1);
        check_val("clr_code",   {24'h0, cmd_code}, 32'h01);
        check_val("clr_cursor", {27'h0, cursor}, 32'h0);
        count_busy(n);
        check_val("clr_busyn", n, CLEAR_N);
        do_strobe(1'b1, 1'b0, 8'h41);
        check_val("wa_cursor", {27'h0, cursor}, 32'h1);
        count_busy(n);
        check_val("wa_busyn", n, BUSY_N);
        check_all_space("clr_ddr", 0, 8'h41);

        // Set DDRAM address 0xC5, write '9', then same-cycle read/write
        do_strobe(1'b0, 1'b0, 8'hC5);
        check_val("c5_cursor", {27'h0, cursor}, 32'd21);
        count_busy(n);
        do_strobe(1'b1, 1'b0, 8'h39);
        check_val("w39_cursor", {27'h0, cursor}, 32'd22);
        count_busy(n);
        read_ddr(21, v);
        check_val("w39_rd21", {24'h0, v}, 32'h39);
        rd_addr = 5'd22;
        do_strobe(1'b1, 1'b0, 8'h3A);
        check_val("rw_same_old", {24'h0, rd_char}, 32'h20);
        tick();
        check_val("rw_same_new", {24'h0, rd_char}, 32'h3A);
        count_busy(n);

        // Entry mode decrement, wrap 0 -> 31
        do_strobe(1'b0, 1'b0, 8'h04);
        check_val("ent_code", {24'h0, cmd_code}, 32'h04);
        count_busy(n);
        do_strobe(1'b0, 1'b0, 8'h80);
        check_val("a80_cursor", {27'h0, cursor}, 32'h0);
        count_busy(n);
        do_strobe(1'b1, 1'b0, 8'h58);
        check_val("w58_cursor", {27'h0, cursor}, 32'd31);
        count_busy(n);
        read_ddr(0, v);
        check_val("w58_rd0", {24'h0, v}, 32'h58);

        // Overrun: second strobe 100 cycles into a data write busy window
        do_strobe(1'b1, 1'b0, 8'h11);
        check_val("w11_cursor", {27'h0, cursor}, 32'd30);
        repeat (100) tick();
        do_strobe(1'b1, 1'b0, 8'h77);
        check_val("ovr_flag",   {31'h0, err_overrun}, 32'h1);
        check_val("ovr_cursor", {27'h0, cursor}, 32'd30);
        count_busy(n);
        check_val("ovr_busyn", n, BUSY_N - 103);
        read_ddr(30, v);
        check_val("ovr_rd30", {24'h0, v}, 32'h20);
        read_ddr(31, v);
        check_val("ovr_rd31", {24'h0, v}, 32'h11);

        // Read strobe: no operation, err_rw set
        do_strobe(1'b0, 1'b1, 8'h01);
        check_val("rw_flag",   {31'h0, err_rw}, 32'h1);
        check_val("rw_busy",   {31'h0, busy}, 32'h0);
        check_val("rw_cmdv",   {31'h0, cmd_valid}, 32'h0);
        check_val("rw_cursor", {27'h0, cursor}, 32'd30);

        // Display on, then bad DDRAM address 0xA0
        p0 = pulses;
        do_strobe(1'b0, 1'b0, 8'h0C);
        check_val("dsp_cmdv", {31'h0, cmd_valid}, 32'h1);
        check_val("dsp_on",   {31'h0, display_on}, 32'h1);
        tick();
        check_val("dsp_cmdv_off", {31'h0, cmd_valid}, 32'h0);
        count_busy(n);
        do_strobe(1'b0, 1'b0, 8'hA0);
        check_val("aa0_cmdv",   {31'h0, cmd_valid}, 32'h1);
        check_val("aa0_code",   {24'h0, cmd_code}, 32'hA0);
        check_val("aa0_err",    {31'h0, err_addr}, 32'h1);
        check_val("aa0_cursor", {27'h0, cursor}, 32'h0);
        tick();
        count_busy(n);
        check_val("dsp_pulses", pulses - p0, 32'd2);

        // Reset 10 cycles into a clear; en falls across reset release
        do_strobe(1'b1, 1'b0, 8'h66);
        count_busy(n);
        do_strobe(1'b0, 1'b0, 8'h01);
        repeat (10) tick();
        reset    = 1'b1;
        lcd_en   = 1'b1;
        lcd_rs   = 1'b1;
        lcd_data = 8'h99;
        tick();
        tick();
        reset  = 1'b0;
        lcd_en = 1'b0;
        tick();
        tick();
        check_val("ar_busy",   {31'h0, busy}, 32'h0);
        check_val("ar_cursor", {27'h0, cursor}, 32'h0);
        check_val("ar_errs",   {29'h0, err_overrun, err_rw, err_addr}, 32'h0);
        check_val("ar_disp",   {31'h0, display_on}, 32'h0);
        check_val("ar_code",   {24'h0, cmd_code}, 32'h0);
        check_all_space("ar_ddr", -1, 8'h00);
        do_strobe(1'b1, 1'b0, 8'h42);
        check_val("ar_w_busy",   {31'h0, busy}, 32'h1);
        check_val("ar_w_cursor", {27'h0, cursor}, 32'h1);
        check_val("ar_w_ovr",    {31'h0, err_overrun}, 32'h0);
        count_busy(n);
        check_val("ar_w_busyn", n, BUSY_N);
        read_ddr(0, v);
        check_val("ar_w_rd0", {24'h0, v}, 32'h42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_responder.md
LCD_RESPONDER -- requirements
Module: lcd_responder

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 2000, giving the busy time in clk cycles for normal commands and data writes (40 us at 50 MHz).
REQ-002 SHALL have parameter CLEAR_CYCLES, default 82000, giving the busy time in clk cycles for clear and home commands (1.64 ms); legal range is 32 or more.
REQ-003 SHALL have port clk, input, 1 bit: single clock; the block has one clock and every register is on clk.
REQ-004 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 SHALL have port lcd_data, input, 8 bits: LCD bus data from the controller.
REQ-006 SHALL have ports lcd_en, lcd_rs and lcd_rw, each input, 1 bit: LCD bus strobe, register select and read/write.
REQ-007 SHALL have port rd_addr, input, 5 bits: DDRAM readback index; 0-15 is line 1 and 16-31 is line 2.
REQ-008 SHALL have port rd_char, output, 8 bits: DDRAM byte at rd_addr, registered.
REQ-009 SHALL have port cursor, output, 5 bits: current DDRAM index.
REQ-010 SHALL have ports busy and display_on, each output, 1 bit: busy emulation and the display-on bit of display control.
REQ-011 SHALL have ports cmd_valid (output, 1 bit) and cmd_code (output, 8 bits): one-cycle pulse plus the accepted instruction byte (RS=0 only).
REQ-012 SHALL have ports err_overrun, err_rw and err_addr, each output, 1 bit: sticky error flags.

Function
REQ-013 SHALL register lcd_en once and detect a strobe as previous en=1 and current en=0; the strobe SHALL capture lcd_rs, lcd_rw and lcd_data from the last cycle en was high.
REQ-014 SHALL act on a strobe in the cycle after detection; cmd_valid, busy rise and the DDRAM/cursor update SHALL all occur in that same cycle.
REQ-015 SHALL, for a strobe with rw=1, perform no operation and set err_rw.
REQ-016 SHALL, for a strobe while busy=1, drop the strobe, set err_overrun and leave the busy count unchanged.
REQ-017 SHALL, on an accepted strobe, load the busy counter and hold busy=1 for exactly N cycles, where N is CLEAR_CYCLES for 0x01, 0x02 and 0x03 and BUSY_CYCLES for all others.
REQ-018 SHALL, for RS=0 with byte 0x01 (clear), set cursor=0, set I/D=1 and fill DDRAM with 0x20 at one byte per cycle (index 0 to 31, 32 cycles), all within the busy window.
REQ-019 SHALL, for RS=0 with byte 0x02 or 0x03 (home), set cursor=0 and leave DDRAM unchanged.
REQ-020 SHALL, for RS=0 with byte 0x04-0x07 (entry mode), store bit1 as I/D.
REQ-021 SHALL, for RS=0 with byte 0x08-0x0F (display control), set display_on to bit2.
REQ-022 SHALL, for RS=0 with byte 0x10-0x7F (shift, function set, CGRAM), acknowledge the command only, with no state change.
REQ-023 SHALL, for RS=0 with byte 0x80-0xFF (set DDRAM address), set cursor = {data[6], data[3:0]}, and set err_addr if data[5:4] != 0 while still loading the address.
REQ-024 SHALL, for RS=1 (data write), write DDRAM[cursor]=data, then step cursor by +1 if I/D=1 or -1 if I/D=0, wrapping 31 to 0 and 0 to 31.
REQ-025 SHALL pulse cmd_valid for one cycle only for accepted RS=0 strobes; cmd_code SHALL hold the last accepted instruction.
REQ-026 SHALL update rd_char one cycle after rd_addr; during a clear it SHALL return the partially cleared contents.
REQ-027 SHALL, when a readback and a write hit the same index in the same cycle, return the old value on rd_char.

Reset
REQ-028 SHALL, when reset=1, set busy=0, cmd_valid=0, cmd_code=0x00, cursor=0, I/D=1, display_on=0, rd_char=0x00, all error flags=0 and every DDRAM byte=0x20.
REQ-029 SHALL give reset priority over any strobe in the same cycle; a reset during a clear or busy window SHALL abort it, and an en falling edge spanning reset release SHALL NOT be detected.

Structure
REQ-030 SHALL place the following in shared package lcd_pkg: opcode constants (CLR=0x01, HOME=0x02, ENTRY=0x04, DISP=0x08, DDRAM=0x80), DDRAM_DEPTH=32, SPACE=0x20 and the default busy counts.
REQ-031 SHALL use one sub-module, lcd_strobe_capture (en edge detection plus RS/RW/data capture); the decoder, busy timer and DDRAM SHALL be in lcd_responder.

Verification
REQ-032 Bench SHALL cover: strobe RS=0 0x01, then write 'A' (0x41) after busy falls -> busy high 82000 cycles, DDRAM[0]=0x41, all others 0x20, cursor=1.
REQ-033 Bench SHALL cover: RS=0 0xC5, then RS=1 0x39 -> cursor=21 then 22, and rd_addr=21 gives rd_char=0x39 one cycle later.
REQ-034 Bench SHALL cover: RS=0 0x04, cursor=0, RS=1 0x58 -> DDRAM[0]=0x58, cursor=31.
REQ-035 Bench SHALL cover: second strobe 100 cycles after an accepted data write -> dropped, err_overrun=1, DDRAM unchanged.
REQ-036 Bench SHALL cover: RS=0 0x0C, then 0xA0 -> display_on=1, cmd_valid pulsed twice, err_addr=1, cursor=0.
REQ-037 Bench SHALL cover: reset asserted 10 cycles into a clear -> busy=0, cursor=0, all bytes 0x20, flags 0, next strobe accepted normally.
